l1i_axi_read_master: RTL and testbench

- Downstream neighbour of the L1 instruction cache, inside the CPU wrapper.
- Accepts the cache's miss/refill request on the I_* interface and issues one AXI4 read transaction (AR + R channels).
- Streams returned words back to the cache one beat at a time, with beat index and done/error indications.
- Read-only: instruction memory is never written through this block.

---
 rtl/l1i_axi_read_master_pkg.sv | 25 ++
 rtl/l1i_axi_read_master_if.sv | 54 +++++
 rtl/axi_beat_counter.sv | 42 ++++
 rtl/l1i_axi_read_master.sv | 145 ++++++++++++++
 tb/tb_l1i_axi_read_master.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/l1i_axi_read_master_pkg.sv
// Shared AXI constants and the refill FSM state type for the L1I read master.
// The data-side read master also imports this package.
package l1i_axi_read_master_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } l1i_state_e;

    // EXOKAY is unexpected for a non-exclusive read, so it counts as an error too.
    function automatic logic axi_resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR) ||
               (resp == AXI_RESP_EXOKAY);
    endfunction

endpackage

// File: rtl/l1i_axi_read_master_if.sv
// Cache-side request/beat signals plus the AXI4 AR/R channels of the L1I read master.
// Handshakes: a transfer happens on a rising clk edge where VALID and READY are both high;
// VALID never waits on READY, and payload is held stable while VALID is high and READY low.
interface l1i_axi_read_master_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4,
    parameter int LINE_BEATS = 4
);
    localparam int IDX_W = $clog2(LINE_BEATS);

    logic              I_req;
    logic [ADDR_W-1:0] I_addr;
    logic              I_line;
    logic [DATA_W-1:0] I_out;
    logic              I_beat_valid;
    logic [IDX_W-1:0]  I_beat_idx;
    logic              I_wait;
    logic              I_err;

    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [3:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;

    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        input  I_req, I_addr, I_line,
        output I_out, I_beat_valid, I_beat_idx, I_wait, I_err,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        output I_req, I_addr, I_line,
        input  I_out, I_beat_valid, I_beat_idx, I_wait, I_err,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

endinterface

// File: rtl/axi_beat_counter.sv
// Up-counter for AXI burst beats: clear, load, enable, wrap after MAX and a terminal compare.
module axi_beat_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         at_term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = (cnt_q == W'(MAX)) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign at_term = (cnt_q == term);

endmodule

// File: rtl/l1i_axi_read_master.sv
// Turns one L1I miss/refill request into a single AXI4 read burst and streams the
// returned words back to the cache, flagging bad responses and RLAST framing errors.
module l1i_axi_read_master
    import l1i_axi_read_master_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4,
    parameter int MASTER_ID  = 0,
    parameter int LINE_BEATS = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    l1i_axi_read_master_if.master        bus,
    output l1i_state_e                   dbg_state
);

    localparam int IDX_W = $clog2(LINE_BEATS);
    localparam int OFF_W = $clog2(LINE_BEATS * 4);
    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << 2;
    localparam logic [3:0]        LEN_LINE  = 4'(LINE_BEATS - 1);

    l1i_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              bv_q, bv_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [3:0]        cnt;
    logic              cnt_at_term;

    axi_beat_counter #(
        .W   (4),
        .MAX (LINE_BEATS - 1)
    ) u_beat_cnt (
        .clk      (clk),
        .rst_n    (rstn),
        .clr      (cnt_clr),
        .load     (1'b0),
        .load_val (4'd0),
        .en       (cnt_en),
        .term     (len_q),
        .cnt      (cnt),
        .at_term  (cnt_at_term)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        err_d   = err_q;
        out_d   = out_q;
        bv_d    = 1'b0;
        idx_d   = idx_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.I_req) begin
                    addr_d  = bus.I_line ? (bus.I_addr & LINE_MASK) : (bus.I_addr & WORD_MASK);
                    len_d   = bus.I_line ? LEN_LINE : 4'd0;
                    err_d   = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                if (bus.ARREADY) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (bus.RVALID) begin
                    out_d  = bus.RDATA;
                    bv_d   = 1'b1;
                    idx_d  = cnt[IDX_W-1:0];
                    cnt_en = 1'b1;
                    if (axi_resp_is_err(bus.RRESP) || (bus.RID != ID_W'(MASTER_ID))) begin
                        err_d = 1'b1;
                    end
                    // Burst ends on whichever comes first: expected count or RLAST;
                    // a mismatch between the two is a framing error.
                    if (cnt_at_term) begin
                        if (!bus.RLAST) begin
                            err_d = 1'b1;
                        end
                        state_d = ST_DONE;
                    end else if (bus.RLAST) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
            out_q   <= '0;
            bv_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            err_q   <= err_d;
            out_q   <= out_d;
            bv_q    <= bv_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.ARID         = ID_W'(MASTER_ID);
    assign bus.ARADDR       = addr_q;
    assign bus.ARLEN        = len_q;
    assign bus.ARSIZE       = AXI_SIZE_WORD;
    assign bus.ARBURST      = AXI_BURST_INCR;
    assign bus.ARVALID      = (state_q == ST_AR);
    assign bus.RREADY       = (state_q == ST_R);

    assign bus.I_out        = out_q;
    assign bus.I_beat_valid = bv_q;
    assign bus.I_beat_idx   = idx_q;
    assign bus.I_err        = err_q;
    // Rises combinationally on the accepting cycle; held low while in reset.
    assign bus.I_wait       = rstn & ((state_q != ST_IDLE) | bus.I_req);

    assign dbg_state        = state_q;

endmodule

// File: tb/tb_l1i_axi_read_master.sv
// Directed bench for l1i_axi_read_master: a vector table of refill transactions
// plus hand-written reset-mid-burst and back-to-back sequences.
`timescale 1ns/1ps
module tb_l1i_axi_read_master;
    import l1i_axi_read_master_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int ID_W       = 4;
    localparam int MASTER_ID  = 0;
    localparam int LINE_BEATS = 4;
    localparam int IDX_W      = $clog2(LINE_BEATS);
    localparam int BW         = DATA_W + IDX_W + 1;
    localparam int NONE       = 99;
    localparam int NVEC       = 8;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rstn;
    l1i_state_e dbg_state;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l1i_axi_read_master_if #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ID_W       (ID_W),
        .LINE_BEATS (LINE_BEATS)
    ) bus ();

    l1i_axi_read_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .ID_W       (ID_W),
        .MASTER_ID  (MASTER_ID),
        .LINE_BEATS (LINE_BEATS)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            errors = 0;
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] got_mem [256];
    int            got_n = 0;
    int            rd = 0;

    always @(negedge clk) begin
        if (rstn && bus.I_beat_valid && got_n < 256) begin
            got_mem[got_n] <= {bus.I_out, bus.I_beat_idx, bus.I_err};
            got_n          <= got_n + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drain(input string tag);
        while (rd < got_n) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s:extra_beat got 0x%0h expected none", tag, got_mem[rd]);
            end else begin
                check({tag, ":beat"}, 64'(got_mem[rd]), 64'(exp_q.pop_front()));
            end
            rd++;
        end
        check({tag, ":missing_beats"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.I_req   = 1'b0;
        bus.I_addr  = '0;
        bus.I_line  = 1'b0;
        bus.ARREADY = 1'b0;
        bus.RID     = '0;
        bus.RDATA   = '0;
        bus.RRESP   = AXI_RESP_OKAY;
        bus.RLAST   = 1'b0;
        bus.RVALID  = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic        line;
        logic [31:0] addr;
        logic [31:0] exp_araddr;
        logic [3:0]  exp_arlen;
        int          nsend;
        logic [3:0][31:0] data;
        int          rlast_at;
        int          bad_resp_at;
        logic [1:0]  bad_resp;
        int          bad_id_at;
        int          err_from;
        int          ar_delay;
        int          gap;
        int          exp_lat;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input string name, input logic line, input logic [31:0] addr,
                                input logic [31:0] exp_araddr, input logic [3:0] exp_arlen,
                                input int nsend, input logic [127:0] data, input int rlast_at,
                                input int bad_resp_at, input logic [1:0] bad_resp,
                                input int bad_id_at, input int err_from, input int ar_delay,
                                input int gap, input int exp_lat);
        vec_t v;
        v.name = name;          v.line = line;           v.addr = addr;
        v.exp_araddr = exp_araddr; v.exp_arlen = exp_arlen; v.nsend = nsend;
        v.data = data;          v.rlast_at = rlast_at;   v.bad_resp_at = bad_resp_at;
        v.bad_resp = bad_resp;  v.bad_id_at = bad_id_at; v.err_from = err_from;
        v.ar_delay = ar_delay;  v.gap = gap;             v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int          t0;
        int          lat;
        logic [31:0] d;
        t0 = cyc;
        bus.I_req  = 1'b1;
        bus.I_addr = v.addr;
        bus.I_line = v.line;
        #1;
        check({v.name, ":wait_rise"}, 64'(bus.I_wait), 64'd1);
        tick();
        bus.I_req  = 1'b0;
        bus.I_addr = 32'hFFFF_FFFF;
        check({v.name, ":err_clr"}, 64'(bus.I_err), 64'd0);
        check({v.name, ":state_ar"}, 64'(dbg_state), 64'(ST_AR));
        for (int i = 0; i < v.ar_delay; i++) begin
            check({v.name, ":arvalid_stall"}, 64'(bus.ARVALID), 64'd1);
            check({v.name, ":araddr_stall"}, 64'(bus.ARADDR), 64'(v.exp_araddr));
            tick();
        end
        bus.ARREADY = 1'b1;
        check({v.name, ":arvalid"}, 64'(bus.ARVALID), 64'd1);
        check({v.name, ":araddr"}, 64'(bus.ARADDR), 64'(v.exp_araddr));
        check({v.name, ":arlen"}, 64'(bus.ARLEN), 64'(v.exp_arlen));
        tick();
        bus.ARREADY = 1'b0;
        check({v.name, ":arvalid_drop"}, 64'(bus.ARVALID), 64'd0);
        check({v.name, ":rready"}, 64'(bus.RREADY), 64'd1);
        for (int b = 0; b < v.nsend; b++) begin
            for (int g = 0; g < v.gap; g++) tick();
            d = v.data[b];
            bus.RVALID = 1'b1;
            bus.RDATA  = d;
            bus.RLAST  = (b == v.rlast_at);
            bus.RRESP  = (b == v.bad_resp_at) ? v.bad_resp : AXI_RESP_OKAY;
            bus.RID    = (b == v.bad_id_at) ? 4'h5 : ID_W'(MASTER_ID);
            check({v.name, ":rready_beat"}, 64'(bus.RREADY), 64'd1);
            exp_q.push_back({d, IDX_W'(b), (b >= v.err_from)});
            tick();
            bus.RVALID = 1'b0;
        end
        bus.RLAST = 1'b0;
        bus.RRESP = AXI_RESP_OKAY;
        bus.RID   = '0;
        lat = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!bus.I_wait) begin
                lat = cyc - t0;
                break;
            end
        end
        check({v.name, ":wait_fall_latency"}, 64'(lat), 64'(v.exp_lat));
        check({v.name, ":err_final"}, 64'(bus.I_err), 64'(v.err_from != NONE));
        check({v.name, ":state_idle"}, 64'(dbg_state), 64'(ST_IDLE));
        drain(v.name);
        tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        //                 name           line addr          araddr        len n  data (beat3..beat0)                                     rlast bad_r bad_resp         bad_id err   ard gap lat
        vecs[0] = mk("single",      1'b0, 32'h0000_1006, 32'h0000_1004, 4'd0, 1, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF},                 0,    NONE, AXI_RESP_OKAY,   NONE,  NONE, 0,  0,  4);
        vecs[1] = mk("line_stall",  1'b1, 32'h0000_203C, 32'h0000_2030, 4'd3, 4, {32'h44, 32'h33, 32'h22, 32'h11},                    3,    NONE, AXI_RESP_OKAY,   NONE,  NONE, 3,  1,  14);
        vecs[2] = mk("slverr",      1'b1, 32'h0000_3004, 32'h0000_3000, 4'd3, 4, {32'hA3, 32'hA2, 32'hA1, 32'hA0},                    3,    2,    AXI_RESP_SLVERR, NONE,  2,    0,  0,  7);
        vecs[3] = mk("early_rlast", 1'b1, 32'h0000_4010, 32'h0000_4010, 4'd3, 2, {32'h0, 32'h0, 32'hB1, 32'hB0},                      1,    NONE, AXI_RESP_OKAY,   NONE,  1,    0,  0,  5);
        vecs[4] = mk("no_rlast",    1'b1, 32'h0000_5008, 32'h0000_5000, 4'd3, 4, {32'hC3, 32'hC2, 32'hC1, 32'hC0},                    NONE, NONE, AXI_RESP_OKAY,   NONE,  3,    1,  0,  8);
        vecs[5] = mk("bad_rid",     1'b0, 32'h0000_6003, 32'h0000_6000, 4'd0, 1, {32'h0, 32'h0, 32'h0, 32'hD0},                       0,    NONE, AXI_RESP_OKAY,   0,     0,    0,  2,  6);
        vecs[6] = mk("line_fast",   1'b1, 32'h0000_700F, 32'h0000_7000, 4'd3, 4, {32'hE3, 32'hE2, 32'hE1, 32'hE0},                    3,    NONE, AXI_RESP_OKAY,   NONE,  NONE, 0,  0,  7);
        vecs[7] = mk("decerr",      1'b0, 32'h0000_A00B, 32'h0000_A008, 4'd0, 1, {32'h0, 32'h0, 32'h0, 32'h1234_5678},                0,    0,    AXI_RESP_DECERR, NONE,  0,    0,  0,  4);

        idle_inputs();
        rstn = 1'b0;
        repeat (3) tick();
        check("rst:arvalid", 64'(bus.ARVALID), 64'd0);
        check("rst:rready", 64'(bus.RREADY), 64'd0);
        check("rst:i_wait", 64'(bus.I_wait), 64'd0);
        check("rst:beat_valid", 64'(bus.I_beat_valid), 64'd0);
        check("rst:i_err", 64'(bus.I_err), 64'd0);
        check("rst:i_out", 64'(bus.I_out), 64'd0);
        check("rst:beat_idx", 64'(bus.I_beat_idx), 64'd0);
        check("rst:araddr", 64'(bus.ARADDR), 64'd0);
        check("rst:arlen", 64'(bus.ARLEN), 64'd0);
        check("rst:arsize", 64'(bus.ARSIZE), 64'd2);
        check("rst:arburst", 64'(bus.ARBURST), 64'd1);
        check("rst:arid", 64'(bus.ARID), 64'(MASTER_ID));
        check("rst:state", 64'(dbg_state), 64'(ST_IDLE));
        rstn = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            run_txn(vecs[i]);
        end

        // Reset asserted right after beat 1 of a line refill is accepted.
        bus.I_req  = 1'b1;
        bus.I_addr = 32'h0000_9004;
        bus.I_line = 1'b1;
        tick();
        bus.I_req   = 1'b0;
        bus.ARREADY = 1'b1;
        tick();
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b1;
        bus.RDATA   = 32'h55;
        exp_q.push_back({32'h55, IDX_W'(0), 1'b0});
        tick();
        bus.RDATA = 32'h66;
        tick();
        rstn       = 1'b0;
        bus.RVALID = 1'b0;
        #1;
        check("mid_rst:arvalid", 64'(bus.ARVALID), 64'd0);
        check("mid_rst:rready", 64'(bus.RREADY), 64'd0);
        check("mid_rst:i_wait", 64'(bus.I_wait), 64'd0);
        check("mid_rst:beat_valid", 64'(bus.I_beat_valid), 64'd0);
        check("mid_rst:state", 64'(dbg_state), 64'(ST_IDLE));
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        drain("mid_rst");
        run_txn(vecs[6]);

        // Back-to-back: I_req held high across two single-word requests.
        bus.I_req   = 1'b1;
        bus.I_addr  = 32'h0000_8001;
        bus.I_line  = 1'b0;
        bus.ARREADY = 1'b1;
        tick();
        check("b2b:arvalid1", 64'(bus.ARVALID), 64'd1);
        check("b2b:araddr1", 64'(bus.ARADDR), 64'h0000_8000);
        bus.I_addr = 32'h0000_8012;
        tick();
        check("b2b:state_r1", 64'(dbg_state), 64'(ST_R));
        bus.RVALID = 1'b1;
        bus.RDATA  = 32'hF00D_0001;
        bus.RLAST  = 1'b1;
        exp_q.push_back({32'hF00D_0001, IDX_W'(0), 1'b0});
        tick();
        bus.RVALID = 1'b0;
        check("b2b:state_done", 64'(dbg_state), 64'(ST_DONE));
        check("b2b:wait_done", 64'(bus.I_wait), 64'd1);
        tick();
        check("b2b:state_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("b2b:arvalid_idle", 64'(bus.ARVALID), 64'd0);
        check("b2b:wait_accept", 64'(bus.I_wait), 64'd1);
        tick();
        check("b2b:arvalid2", 64'(bus.ARVALID), 64'd1);
        check("b2b:araddr2", 64'(bus.ARADDR), 64'h0000_8010);
        bus.I_req = 1'b0;
        tick();
        bus.ARREADY = 1'b0;
        bus.RVALID  = 1'b1;
        bus.RDATA   = 32'hF00D_0002;
        bus.RLAST   = 1'b1;
        exp_q.push_back({32'hF00D_0002, IDX_W'(0), 1'b0});
        tick();
        bus.RVALID = 1'b0;
        bus.RLAST  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!bus.I_wait) break;
        end
        check("b2b:wait_fall", 64'(bus.I_wait), 64'd0);
        drain("b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
